// File: rtl/axil_passthru_master.sv
// Single-beat AXI4-Lite master for register-file pass-through access.
// Define PASSTHRU_TIMEOUT_EN to abort a hung transaction with DECERR.
module axil_passthru_master #(
  parameter int AW             = 12,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_start,
  input  logic          i_write,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata,
  output logic [1:0]    o_resp,
  output logic          o_busy,
  output logic          o_done,
  output logic [31:0]   M_AXI_AWADDR,
  output logic [2:0]    M_AXI_AWPROT,
  output logic          M_AXI_AWVALID,
  input  logic          M_AXI_AWREADY,
  output logic [31:0]   M_AXI_WDATA,
  output logic [3:0]    M_AXI_WSTRB,
  output logic          M_AXI_WVALID,
  input  logic          M_AXI_WREADY,
  input  logic [1:0]    M_AXI_BRESP,
  input  logic          M_AXI_BVALID,
  output logic          M_AXI_BREADY,
  output logic [31:0]   M_AXI_ARADDR,
  output logic [2:0]    M_AXI_ARPROT,
  output logic          M_AXI_ARVALID,
  input  logic          M_AXI_ARREADY,
  input  logic [31:0]   M_AXI_RDATA,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE, WR_AW_W, WR_B, RD_AR, RD_R
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          start_ok, expire, abort;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          wr_both;
  logic          aw_d, w_d, ar_d, bready_d, rready_d;
  logic          done_d;
  logic [31:0]   rdata_d;
  logic [1:0]    resp_d;

  assign o_busy   = (state != IDLE);
  assign start_ok = i_start && (state == IDLE);

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID  && M_AXI_BREADY;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID  && M_AXI_RREADY;

  // Each channel is done if it finished earlier or finishes now.
  assign wr_both = (!M_AXI_AWVALID || aw_hs) &&
                   (!M_AXI_WVALID  || w_hs);

  assign M_AXI_AWADDR = 32'(addr_q);
  assign M_AXI_ARADDR = 32'(addr_q);
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;

`ifdef PASSTHRU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  // The start cycle counts as cycle 1; saturates once expired.
  assign expire = o_busy &&
                  (cnt >= CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (start_ok) begin
      cnt <= CW'(1);
    end else if (o_busy && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_start) state_nx = i_write ? WR_AW_W : RD_AR;
      end
      WR_AW_W: begin
        if (wr_both)     state_nx = WR_B;
        else if (expire) state_nx = IDLE;
      end
      WR_B: begin
        if (b_hs || expire) state_nx = IDLE;
      end
      RD_AR: begin
        if (ar_hs)       state_nx = RD_R;
        else if (expire) state_nx = IDLE;
      end
      RD_R: begin
        if (r_hs || expire) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A handshake in the expiry cycle completes normally.
  assign abort = expire && (state_nx == IDLE) &&
                 !b_hs && !r_hs;

  always_comb begin
    aw_d     = M_AXI_AWVALID && !M_AXI_AWREADY;
    w_d      = M_AXI_WVALID  && !M_AXI_WREADY;
    ar_d     = M_AXI_ARVALID && !M_AXI_ARREADY;
    bready_d = (state_nx == WR_B);
    rready_d = (state_nx == RD_R);
    rdata_d  = o_rdata;
    resp_d   = o_resp;
    done_d   = 1'b0;
    if (start_ok) begin
      aw_d = i_write;
      w_d  = i_write;
      ar_d = !i_write;
    end
    if (b_hs) begin
      resp_d = M_AXI_BRESP;
      done_d = 1'b1;
    end
    if (r_hs) begin
      rdata_d = M_AXI_RDATA;
      resp_d  = M_AXI_RRESP;
      done_d  = 1'b1;
    end
    if (abort) begin
      aw_d   = 1'b0;
      w_d    = 1'b0;
      ar_d   = 1'b0;
      resp_d = 2'b11;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      o_rdata       <= '0;
      o_resp        <= '0;
      o_done        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      M_AXI_AWVALID <= aw_d;
      M_AXI_WVALID  <= w_d;
      M_AXI_BREADY  <= bready_d;
      M_AXI_ARVALID <= ar_d;
      M_AXI_RREADY  <= rready_d;
      o_rdata       <= rdata_d;
      o_resp        <= resp_d;
      o_done        <= done_d;
      if (start_ok) begin
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
      end
    end
  end

endmodule

// File: tb/tb_axil_passthru_master.sv
// Directed bench for axil_passthru_master with a scripted slave.
// Timeout steps run only with PASSTHRU_TIMEOUT_EN defined.
module tb_axil_passthru_master;

  logic        clk;
  logic        resetn;
  logic        i_start, i_write;
  logic [11:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic [1:0]  o_resp;
  logic        o_busy, o_done;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  axil_passthru_master #(
    .AW(12),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .i_start(i_start),
    .i_write(i_write),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .o_rdata(o_rdata),
    .o_resp(o_resp),
    .o_busy(o_busy),
    .o_done(o_done),
    .M_AXI_AWADDR(awaddr),
    .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  int cyc = 0;
  int done_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Slave knobs set by the stimulus.
  int          aw_lat = 0, w_lat = 0, ar_lat = 0;
  logic        aw_hang = 0, r_hold = 0;
  logic [1:0]  bresp_v = 0, rresp_v = 0;
  logic [31:0] rdata_v = 0;

  // Slave state.
  int   aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic aw_acc = 0, w_acc = 0, ar_acc = 0;
  logic b_took = 0, r_took = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (o_done) done_cnt++;

  // Slave updates on the falling edge; the DUT samples on the rising edge.
  always @(negedge clk) begin
    if (!resetn) begin
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
      aw_acc = 0; w_acc = 0; ar_acc = 0;
      b_took = 0; r_took = 0;
    end else begin
      if (b_took) begin
        bvalid = 0; b_took = 0;
      end else if (!bvalid && aw_acc && w_acc) begin
        bvalid = 1; bresp = bresp_v;
        aw_acc = 0; w_acc = 0;
      end
      if (bvalid && bready) b_took = 1;

      if (r_took) begin
        rvalid = 0; r_took = 0;
      end else if (!rvalid && ar_acc && !r_hold) begin
        rvalid = 1; rdata = rdata_v; rresp = rresp_v;
        ar_acc = 0;
      end
      if (rvalid && rready) r_took = 1;

      if (awvalid && !aw_acc) begin
        if (!aw_hang && aw_wait >= aw_lat) begin
          awready = 1; aw_acc = 1;
        end else begin
          awready = 0; aw_wait++;
        end
      end else begin
        awready = 0; aw_wait = 0;
      end

      if (wvalid && !w_acc) begin
        if (w_wait >= w_lat) begin
          wready = 1; w_acc = 1;
        end else begin
          wready = 0; w_wait++;
        end
      end else begin
        wready = 0; w_wait = 0;
      end

      if (arvalid && !ar_acc) begin
        if (ar_wait >= ar_lat) begin
          arready = 1; ar_acc = 1;
        end else begin
          arready = 0; ar_wait++;
        end
      end else begin
        arready = 0; ar_wait = 0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_done) begin
        at = cyc;
        break;
      end
    end
  endtask

  int n0, at, base;

  initial begin
    resetn = 0; i_start = 0; i_write = 0;
    i_addr = 0; i_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_resp", 32'(o_resp), 0);
    resetn = 1;
    @(negedge clk);

    // Zero-wait write.
    bresp_v = 0;
    n0 = cyc;
    i_start = 1; i_write = 1;
    i_addr = 12'h104; i_wdata = 32'hA5A5_0001;
    @(negedge clk);
    i_start = 0;
    chk("w1_busy", 32'(o_busy), 1);
    chk("w1_awvalid", 32'(awvalid), 1);
    chk("w1_wvalid", 32'(wvalid), 1);
    chk("w1_awaddr", awaddr, 32'h104);
    chk("w1_wdata", wdata, 32'hA5A5_0001);
    chk("w1_wstrb", 32'(wstrb), 32'hF);
    chk("w1_awprot", 32'(awprot), 0);
    wait_done(at);
    chk("w1_latency", 32'(at - n0), 3);
    chk("w1_resp", 32'(o_resp), 0);
    chk("w1_bready_off", 32'(bready), 0);
    @(negedge clk);

    // Read with ARREADY stall and an ignored mid-read start.
    ar_lat = 3; rdata_v = 32'h1234_5678; rresp_v = 2;
    base = done_cnt;
    n0 = cyc;
    i_start = 1; i_write = 0; i_addr = 12'h110;
    @(negedge clk);
    i_start = 0;
    chk("r1_arvalid", 32'(arvalid), 1);
    chk("r1_araddr", araddr, 32'h110);
    chk("r1_awvalid", 32'(awvalid), 0);
    @(negedge clk);
    i_start = 1; i_write = 1; i_addr = 12'h000;
    chk("r1_arvalid_hold", 32'(arvalid), 1);
    chk("r1_rready_early", 32'(rready), 0);
    @(negedge clk);
    i_start = 0;
    chk("r1_ign_araddr", araddr, 32'h110);
    chk("r1_ign_awvalid", 32'(awvalid), 0);
    chk("r1_ign_wvalid", 32'(wvalid), 0);
    wait_done(at);
    chk("r1_latency", 32'(at - n0), 6);
    chk("r1_rdata", o_rdata, 32'h1234_5678);
    chk("r1_resp", 32'(o_resp), 2);
    repeat (3) @(negedge clk);
    chk("r1_one_done", 32'(done_cnt - base), 1);

    // Write where W completes four cycles before AW.
    ar_lat = 0; aw_lat = 4; w_lat = 0; bresp_v = 0;
    n0 = cyc;
    i_start = 1; i_write = 1;
    i_addr = 12'h020; i_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    i_start = 0;
    chk("w2_wvalid", 32'(wvalid), 1);
    @(negedge clk);
    chk("w2_wvalid_drop", 32'(wvalid), 0);
    chk("w2_awvalid_hold", 32'(awvalid), 1);
    chk("w2_bready_n2", 32'(bready), 0);
    chk("w2_awaddr", awaddr, 32'h020);
    repeat (3) @(negedge clk);
    chk("w2_awvalid_n5", 32'(awvalid), 1);
    chk("w2_bready_n5", 32'(bready), 0);
    @(negedge clk);
    chk("w2_bready_n6", 32'(bready), 1);
    chk("w2_awvalid_n6", 32'(awvalid), 0);
    wait_done(at);
    chk("w2_latency", 32'(at - n0), 7);
    chk("w2_resp", 32'(o_resp), 0);
    chk("w2_rdata_kept", o_rdata, 32'h1234_5678);

    // Back-to-back read started in the done cycle, then reset in RD_R.
    r_hold = 1; rdata_v = 32'hDEAD_BEEF; rresp_v = 0;
    i_start = 1; i_write = 0; i_addr = 12'h0FC;
    @(negedge clk);
    i_start = 0;
    chk("r2_arvalid", 32'(arvalid), 1);
    chk("r2_araddr", araddr, 32'h0FC);
    @(negedge clk);
    chk("r2_rready", 32'(rready), 1);
    chk("r2_busy", 32'(o_busy), 1);
    #2 resetn = 0;
    #1;
    chk("ar_rst_rready", 32'(rready), 0);
    chk("ar_rst_arvalid", 32'(arvalid), 0);
    chk("ar_rst_awvalid", 32'(awvalid), 0);
    chk("ar_rst_wvalid", 32'(wvalid), 0);
    chk("ar_rst_bready", 32'(bready), 0);
    chk("ar_rst_busy", 32'(o_busy), 0);
    chk("ar_rst_rdata", o_rdata, 0);
    chk("ar_rst_resp", 32'(o_resp), 0);

`ifdef PASSTHRU_TIMEOUT_EN
    r_hold = 0; aw_hang = 1; aw_lat = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    n0 = cyc;
    i_start = 1; i_write = 1;
    i_addr = 12'h030; i_wdata = 32'h5555_AAAA;
    @(negedge clk);
    i_start = 0;
    wait_done(at);
    chk("to_latency", 32'(at - n0), 20);
    chk("to_awvalid", 32'(awvalid), 0);
    chk("to_wvalid", 32'(wvalid), 0);
    chk("to_resp", 32'(o_resp), 3);
    chk("to_busy", 32'(o_busy), 0);
    chk("to_rdata", o_rdata, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
